// File: rtl/sram_like_responder.sv
// SRAM-like bus memory responder: in-order pending queue, response exactly LATENCY cycles after accept.
// Backpressure only via addr_ok (full queue or accept_en=0); data_ok cannot be stalled.
module sram_like_responder #(
    parameter int AW          = 12,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        accept_en,
    output logic        addr_ok,
    output logic [31:0] rdata,
    output logic        data_ok
);
    localparam int         PW       = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int         DEPTH    = 1 << AW;
    localparam logic [2:0] OUT_C    = 3'(OUTSTANDING);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef struct packed {
        logic        vld;
        logic        is_wr;
        logic [31:0] dat;
        logic [3:0]  cnt;
    } entry_t;

    entry_t        q_q [OUTSTANDING];
    entry_t        q_d [OUTSTANDING];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [2:0]    count_q, count_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          push, pop;
    entry_t        head_e;
    logic          unused_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx         = addr[AW+1:2];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

    // No pop bypass: a full queue blocks acceptance even while the head is responding.
    assign addr_ok = ~rst & accept_en & (count_q < OUT_C);
    assign push    = req & addr_ok;
    assign head_e  = q_q[head_q];
    assign data_ok = head_e.vld & (head_e.cnt == 4'd0);
    assign pop     = data_ok;
    assign rdata   = (data_ok && !head_e.is_wr) ? head_e.dat : 32'h0;

    always_comb begin
        q_d     = q_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (q_d[i].vld && q_d[i].cnt != 4'd0) begin
                q_d[i].cnt = q_d[i].cnt - 4'd1;
            end
        end
        if (pop) begin
            q_d[head_q].vld = 1'b0;
            head_d          = ptr_inc(head_q);
        end
        if (push) begin
            q_d[tail_q].vld   = 1'b1;
            q_d[tail_q].is_wr = wr;
            q_d[tail_q].dat   = wr ? 32'h0 : mem[idx];
            q_d[tail_q].cnt   = CNT_INIT;
            tail_d            = ptr_inc(tail_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                q_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            q_q     <= q_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Backing store is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (push && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && count_q == OUT_C));
endmodule
